// File: rtl/interp_pkg.sv
// interp_pkg: shared constants, FSM states and FIR tag type for the interpolation sequencer.
package interp_pkg;
   localparam int NUM_PIXEL = 8;
   localparam int TAPS = 8;
   localparam int HROWS = NUM_PIXEL + TAPS - 1;
   localparam int VROWS = 3 * NUM_PIXEL;
   localparam int H_OFS = TAPS / 2 - 1;
   localparam logic [1:0] SRC_IN = 2'd0, SRC_A = 2'd1, SRC_B = 2'd2, SRC_C = 2'd3;
   localparam logic [1:0] GRP_H = 2'd0, GRP_A = 2'd1, GRP_B = 2'd2, GRP_C = 2'd3;
   typedef enum logic [2:0] {IDLE, HORIZ, VERT, FLUSH, DONE} state_t;
   typedef struct packed {
      logic       valid;
      logic [1:0] grp;
      logic [3:0] row;
   } tag_t;
endpackage

// File: rtl/interp_tag_pipe.sv
// interp_tag_pipe: LAT-deep tag delay line matching FIR latency, with sync clear.
module interp_tag_pipe
   import interp_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  tag_t d,
   output tag_t q
);
   tag_t pipe [LAT];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= clr ? '0 : d;
         for (int i = 1; i < LAT; i++) pipe[i] <= clr ? '0 : pipe[i-1];
      end
   end
   assign q = pipe[LAT-1];
endmodule

// File: rtl/interp_sequencer.sv
// interp_sequencer: steps one 8x8 interpolation job through the shared FIR array,
// horizontal rows first, then the A/B/C vertical feedback passes.
module interp_sequencer
   import interp_pkg::*;
#(
   parameter int FIR_LAT = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] cnt,
   output logic [1:0]       src_sel,
   output logic [3:0]       row_idx,
   output logic             fir_en,
   output logic             sr_load,
   output logic [3:0]       sr_row,
   output logic             out_load,
   output logic [1:0]       out_grp,
   output logic [2:0]       out_row
);
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0] row_q, row_d;
   logic [1:0] src_q, src_d;
   tag_t tag_in, tag_out;
   logic h_hit;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         row_q <= '0;
         src_q <= SRC_IN;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         row_q <= row_d;
         src_q <= src_d;
      end
   end
   // cnt_q doubles as the drain counter in FLUSH; it is masked off there
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      row_d = row_q;
      src_d = src_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = HORIZ;
            cnt_d = '0;
            row_d = '0;
            src_d = SRC_IN;
         end
         HORIZ: begin
            cnt_d = cnt_q + 1'b1;
            row_d = row_q + 4'd1;
            if (row_q == 4'(HROWS - 1)) begin
               state_d = VERT;
               row_d = '0;
               src_d = SRC_A;
            end
         end
         VERT: begin
            cnt_d = cnt_q + 1'b1;
            row_d = row_q + 4'd1;
            if (row_q == 4'(NUM_PIXEL - 1)) begin
               row_d = '0;
               src_d = src_q + 2'd1;
               if (src_q == SRC_C) begin
                  state_d = FLUSH;
                  cnt_d = '0;
               end
            end
         end
         FLUSH: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(FIR_LAT - 1)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end
   assign in_ready = state_q == IDLE;
   assign busy = !in_ready;
   assign done = state_q == DONE;
   assign fir_en = state_q == HORIZ || state_q == VERT;
   assign cnt = fir_en ? cnt_q : '0;
   assign src_sel = fir_en ? src_q : SRC_IN;
   assign row_idx = fir_en ? row_q : '0;
   // source and output-group encodings coincide, so the tag group is just src_sel
   assign tag_in = '{valid: fir_en, grp: src_sel, row: row_idx};
   interp_tag_pipe #(.LAT(FIR_LAT)) u_tag_pipe (
      .clk(clk),
      .rst(rst),
      .clr(abort),
      .d(tag_in),
      .q(tag_out)
   );
   assign sr_load = tag_out.valid && tag_out.grp == GRP_H;
   assign sr_row = sr_load ? tag_out.row : '0;
   assign h_hit = sr_load && tag_out.row >= 4'(H_OFS) && tag_out.row < 4'(H_OFS + NUM_PIXEL);
   assign out_load = h_hit || (tag_out.valid && tag_out.grp != GRP_H);
   assign out_grp = out_load ? tag_out.grp : GRP_H;
   assign out_row = !out_load ? '0 : h_hit ? 3'(tag_out.row - 4'(H_OFS)) : tag_out.row[2:0];
endmodule
